mux_scan_ctrl: RTL

- Upstream/downstream companion to the 4:1 single-bit multiplexer: drives its 2-bit select and captures its output.
- On Start, steps Sel through channels 0..3. For each channel it waits a settle interval, then samples Mux_out into bit [Sel] of a 4-bit vector.
- Presents the completed vector on a valid/ready handshake.
- Used as the scan front-end that turns four slow single-bit sources into one parallel word.

---
 rtl/mux_scan_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps Sel 0..3, samples Mux_out per channel, presents a 4-bit word.
// Latency: Vld rises 4*(SETTLE_CYCLES+1) cycles after Start (4*(SETTLE_CYCLES+3) with MUX_SCAN_MAJORITY_EN).
// Backpressure: result held with Vld=1 until Rdy; Continuous restarts the scan on each accepted result.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Continuous,
    input  logic       Mux_out,
    output logic [1:0] Sel,
    output logic [3:0] Sample_vec,
    output logic       Vld,
    input  logic       Rdy,
    output logic       Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       vec_q, vec_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             cap_en;
    logic             cap_bit;

`ifdef MUX_SCAN_MAJORITY_EN
    // Three-cycle sample window: two earlier samples held in hist_q, third taken live.
    logic [1:0] smp_cnt_q, smp_cnt_d;
    logic [1:0] hist_q, hist_d;

    assign cap_en  = (smp_cnt_q == 2'd2);
    assign cap_bit = (hist_q[1] & hist_q[0]) | ((hist_q[1] | hist_q[0]) & Mux_out);

    always_comb begin
        smp_cnt_d = smp_cnt_q;
        hist_d    = hist_q;
        if (state_q == S_SAMPLE) begin
            hist_d    = {hist_q[0], Mux_out};
            smp_cnt_d = cap_en ? 2'd0 : smp_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            smp_cnt_q <= 2'd0;
            hist_q    <= 2'd0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
            hist_q    <= hist_d;
        end
    end
`else
    assign cap_en  = 1'b1;
    assign cap_bit = Mux_out;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                sel_d = 2'd0;
                if (Start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    vec_d   = 4'd0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end
            end
            S_SAMPLE: begin
                if (cap_en) begin
                    vec_d[sel_q] = cap_bit;
                    if (sel_q == 2'd3) begin
                        state_d = S_HOLD;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        sel_d   = sel_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
            end
            S_HOLD: begin
                if (Rdy) begin
                    vld_d = 1'b0;
                    sel_d = 2'd0;
                    if (Continuous) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                        vec_d   = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            vec_q   <= 4'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign Sel        = sel_q;
    assign Sample_vec = vec_q;
    assign Vld        = vld_q;
    assign Busy       = busy_q;

endmodule
